logic_arb: RTL and testbench

- Shares one instance of the 32-bit logic unit (and/or/xor/nor/lui) between two requesters.
- Typical requesters: the EX stage (req0) and a secondary issue path such as a multi-cycle helper or debug port (req1).
- Round-robin arbitration, valid/ready handshakes on each request port, and a single registered response channel tagged with the winning requester id.
- Latency is one cycle from request acceptance to response valid. Full throughput when the response is drained every cycle.

---
 rtl/logic_arb_pkg.sv | 29 ++
 rtl/logic_arb_unit.sv | 41 ++++
 rtl/logic_arb.sv | 132 +++++++++++++
 tb/tb_logic_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: constants and types shared by the logic unit arbiter.
//   TYPE_W            width of the one-hot operation select
//   LOGIC_*           bit position of each operation inside the select
//   REQ_EX / REQ_AUX  requester ids carried on res_id
//   buf_state_t       occupancy of the one-entry response buffer
//   is_one_hot        true when the select has exactly one bit set
package logic_arb_pkg;

   localparam int TYPE_W    = 5;

   localparam int LOGIC_AND = 0;
   localparam int LOGIC_OR  = 1;
   localparam int LOGIC_XOR = 2;
   localparam int LOGIC_NOR = 3;
   localparam int LOGIC_LUI = 4;

   localparam logic REQ_EX  = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   function automatic logic is_one_hot(input logic [TYPE_W-1:0] t);
      return (t != '0) && ((t & (t - TYPE_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/logic_arb_unit.sv
// logic_arb_unit: combinational 32-bit logic unit (and/or/xor/nor/lui).
//   a, b     operands
//   op_type  one-hot select (bit positions from logic_arb_pkg); several bits
//            set OR their results together, no bits set gives zero
//   res      result
module logic_arb_unit
   import logic_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [TYPE_W-1:0] op_type,
   output logic [DATA_W-1:0] res
);

   logic [DATA_W-1:0] op_val [TYPE_W];
   logic [DATA_W-1:0] op_sel [TYPE_W];

   assign op_val[LOGIC_AND] = a & b;
   assign op_val[LOGIC_OR]  = a | b;
   assign op_val[LOGIC_XOR] = a ^ b;
   assign op_val[LOGIC_NOR] = ~(a | b);
   // lui places the low half of b in the upper half of the result
   assign op_val[LOGIC_LUI] = {b[15:0], {(DATA_W-16){1'b0}}};

   genvar gi;
   generate
      for (gi = 0; gi < TYPE_W; gi++) begin : g_op
         assign op_sel[gi] = op_type[gi] ? op_val[gi] : '0;
      end
   endgenerate

   always_comb begin
      res = '0;
      for (int i = 0; i < TYPE_W; i++) begin
         res = res | op_sel[i];
      end
   end

endmodule

// File: rtl/logic_arb.sv
// logic_arb: round-robin sharing of one logic unit between two requesters,
// with a one-entry registered response buffer (1-cycle latency, full
// throughput when the response is drained every cycle).
//   clk, resetn                          clock, async active-low reset
//   r0_valid/r0_ready/r0_a/r0_b/r0_type  requester 0 (REQ_EX) handshake
//   r1_valid/r1_ready/r1_a/r1_b/r1_type  requester 1 (REQ_AUX) handshake
//   res_valid/res_ready                  response handshake
//   res, res_id                          registered result and its requester
//   res_err                              only with LOGIC_ARB_ERR_EN defined:
//                                        granted type was not exactly one-hot
// The op select width TYPE_W comes from logic_arb_pkg since the bit
// positions of the operations are fixed there.
module logic_arb
   import logic_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [TYPE_W-1:0] r0_type,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [TYPE_W-1:0] r1_type,
   output logic              res_valid,
   input  logic              res_ready,
`ifdef LOGIC_ARB_ERR_EN
   output logic              res_err,
`endif
   output logic [DATA_W-1:0] res,
   output logic              res_id
);

   buf_state_t        state_reg, state_next;
   logic              rr_ptr_reg, rr_ptr_next;
   logic [DATA_W-1:0] res_reg;
   logic              res_id_reg;

   logic              can_accept;
   logic              both_valid;
   logic              grant;
   logic              grant_id;
   logic [DATA_W-1:0] sel_a, sel_b, unit_res;
   logic [TYPE_W-1:0] sel_type;

   // ---------------- arbitration ----------------
   // resetn gates the grant so both readys drop as soon as reset asserts
   assign can_accept = (state_reg == BUF_EMPTY) || res_ready;
   assign both_valid = r0_valid && r1_valid;
   assign grant_id   = both_valid ? rr_ptr_reg : (r1_valid ? REQ_AUX : REQ_EX);
   assign grant      = resetn && can_accept && (r0_valid || r1_valid);

   assign sel_a    = (grant_id == REQ_AUX) ? r1_a    : r0_a;
   assign sel_b    = (grant_id == REQ_AUX) ? r1_b    : r0_b;
   assign sel_type = (grant_id == REQ_AUX) ? r1_type : r0_type;

   logic_arb_unit #(.DATA_W(DATA_W)) u_unit (
      .a       (sel_a),
      .b       (sel_b),
      .op_type (sel_type),
      .res     (unit_res)
   );

   // pointer only moves on a contended grant, to the loser
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant && both_valid) begin
         rr_ptr_next = ~grant_id;
      end
   end

   // ---------------- response buffer FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= BUF_EMPTY;
         rr_ptr_reg <= REQ_EX;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // a grant always (re)fills the buffer, covering drain-and-reload
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BUF_EMPTY: if (grant) state_next = BUF_FULL;
         BUF_FULL:  if (res_ready && !grant) state_next = BUF_EMPTY;
         default:   state_next = BUF_EMPTY;
      endcase
   end

   always_comb begin
      res_valid = (state_reg == BUF_FULL);
      r0_ready  = grant && (grant_id == REQ_EX);
      r1_ready  = grant && (grant_id == REQ_AUX);
   end

   // result data only loads on a grant; it holds across a plain drain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_reg    <= '0;
         res_id_reg <= REQ_EX;
      end else if (grant) begin
         res_reg    <= unit_res;
         res_id_reg <= grant_id;
      end
   end

   assign res    = res_reg;
   assign res_id = res_id_reg;

`ifdef LOGIC_ARB_ERR_EN
   logic res_err_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_err_reg <= 1'b0;
      end else if (grant) begin
         res_err_reg <= !is_one_hot(sel_type);
      end
   end

   assign res_err = res_err_reg;
`endif

endmodule

// File: tb/tb_logic_arb.sv
// tb_logic_arb: randomized and directed stimulus for logic_arb, checked
// against a transaction-level model of the arbiter and response buffer.
module tb_logic_arb;

   logic        clk;
   logic        resetn;
   logic        r0_valid, r1_valid;
   logic        r0_ready, r1_ready;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [4:0]  r0_type, r1_type;
   logic        res_valid, res_ready;
   logic [31:0] res;
   logic        res_id;
`ifdef LOGIC_ARB_ERR_EN
   logic        res_err;
`endif

   logic_arb #(.DATA_W(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r0_type   (r0_type),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .r1_type   (r1_type),
      .res_valid (res_valid),
      .res_ready (res_ready),
`ifdef LOGIC_ARB_ERR_EN
      .res_err   (res_err),
`endif
      .res       (res),
      .res_id    (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: what the response channel should show
   logic        m_valid;
   logic [31:0] m_res;
   logic        m_id;
   logic        m_err;
   logic        m_rr;
   logic        last_g0, last_g1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] t);
      logic [31:0] r;
      r = 32'h0;
      if (t[0]) r = r | (a & b);
      if (t[1]) r = r | (a | b);
      if (t[2]) r = r | (a ^ b);
      if (t[3]) r = r | ~(a | b);
      if (t[4]) r = r | {b[15:0], 16'h0000};
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_res   = 32'h0;
      m_id    = 1'b0;
      m_err   = 1'b0;
      m_rr    = 1'b0;
   endtask

   // Called just after a falling edge: drive inputs, check readys, take the
   // rising edge, update the model, check the response at the next fall.
   task automatic drive_cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [4:0] t0,
                              input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [4:0] t1, input logic rrdy);
      logic can, g0, g1, win;
      r0_valid = v0; r0_a = a0; r0_b = b0; r0_type = t0;
      r1_valid = v1; r1_a = a1; r1_b = b1; r1_type = t1;
      res_ready = rrdy;
      #1;
      can = !m_valid || rrdy;
      win = (v0 && v1) ? m_rr : v1;
      g0  = can && (v0 || v1) && !win;
      g1  = can && (v0 || v1) && win;
      check("r0_ready", r0_ready, g0);
      check("r1_ready", r1_ready, g1);
      last_g0 = g0;
      last_g1 = g1;
      @(posedge clk);
      if (g0 || g1) begin
         m_valid = 1'b1;
         m_id    = win;
         m_res   = win ? ref_op(a1, b1, t1) : ref_op(a0, b0, t0);
         m_err   = win ? ($countones(t1) != 1) : ($countones(t0) != 1);
         if (v0 && v1) m_rr = !win;
         $display("txn id=%0d type=%b res=%h", win, win ? t1 : t0, m_res);
      end else if (rrdy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check("res_valid", res_valid, m_valid);
      check("res", res, m_res);
      check("res_id", res_id, m_id);
`ifdef LOGIC_ARB_ERR_EN
      if (m_valid) check("res_err", res_err, m_err);
`endif
   endtask

   function automatic logic [4:0] rand_type();
      logic [4:0] t;
      if ($urandom_range(0, 7) == 0) t = 5'($urandom_range(0, 31));
      else                          t = 5'(1 << $urandom_range(0, 4));
      return t;
   endfunction

   logic [31:0] saved_res;
   logic        p0, p1;
   logic        nv0, nv1, nrdy;
   logic [31:0] na0, nb0, na1, nb1;
   logic [4:0]  nt0, nt1;

   initial begin
      model_reset();
      resetn   = 1'b0;
      r0_valid = 1'b1; r0_a = 32'h0; r0_b = 32'h0; r0_type = 5'b00001;
      r1_valid = 1'b1; r1_a = 32'h0; r1_b = 32'h0; r1_type = 5'b00001;
      res_ready = 1'b1;
      #12;
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res", res, 32'h0);
      check("rst_res_id", res_id, 1'b0);
      check("rst_r0_ready", r0_ready, 1'b0);
      check("rst_r1_ready", r1_ready, 1'b0);
      @(negedge clk);
      resetn = 1'b1;

      // contention right after reset: r0 preferred, then strict alternation
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 32'h1234_0000, 32'h0000_5678, 5'b00010,
                     1'b1, 32'hDEAD_BEEF, 32'h0000_ABCD, 5'b10000, 1'b1);
         check("cont_id", res_id, i % 2);
         check("cont_valid", res_valid, 1'b1);
         check("cont_res", res, (i % 2) ? 32'hABCD_0000 : 32'h1234_5678);
      end

      // single requester and
      drive_cycle(1'b1, 32'hF0F0_1234, 32'h0FF0_00FF, 5'b00001,
                  1'b0, 32'h0, 32'h0, 5'b0, 1'b1);
      check("and_res", res, 32'h00F0_0034);
      check("and_id", res_id, 1'b0);

      // nor then xor from requester 1 alone
      drive_cycle(1'b0, 32'h0, 32'h0, 5'b0,
                  1'b1, 32'hFFFF_0000, 32'h00FF_00FF, 5'b01000, 1'b1);
      check("nor_res", res, 32'h0000_FF00);
      drive_cycle(1'b0, 32'h0, 32'h0, 5'b0,
                  1'b1, 32'hFFFF_0000, 32'h00FF_00FF, 5'b00100, 1'b1);
      check("xor_res", res, 32'hFF00_00FF);

      // drain with no new request
      drive_cycle(1'b0, 32'h0, 32'h0, 5'b0, 1'b0, 32'h0, 32'h0, 5'b0, 1'b1);
      check("drain_valid", res_valid, 1'b0);
      check("drain_hold", res, 32'hFF00_00FF);

      // multi-hot and zero types
      drive_cycle(1'b1, 32'h1, 32'h2, 5'b00011, 1'b0, 32'h0, 32'h0, 5'b0, 1'b1);
      check("multi_res", res, 32'h3);
`ifdef LOGIC_ARB_ERR_EN
      check("multi_err", res_err, 1'b1);
`endif
      drive_cycle(1'b1, 32'h1, 32'h2, 5'b00000, 1'b0, 32'h0, 32'h0, 5'b0, 1'b1);
      check("zero_res", res, 32'h0);
`ifdef LOGIC_ARB_ERR_EN
      check("zero_err", res_err, 1'b1);
`endif

      // backpressure: buffer full, consumer stalls three cycles
      drive_cycle(1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'b00010,
                  1'b0, 32'h0, 32'h0, 5'b0, 1'b1);
      saved_res = res;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 32'h1111_0000, 32'h0000_2222, 5'b00010,
                     1'b1, 32'h0, 32'h0000_0042, 5'b10000, 1'b0);
         check("bp_res_stable", res, saved_res);
         check("bp_valid", res_valid, 1'b1);
      end
      drive_cycle(1'b1, 32'h1111_0000, 32'h0000_2222, 5'b00010,
                  1'b1, 32'h0, 32'h0000_0042, 5'b10000, 1'b1);
      check("bp_reload_valid", res_valid, 1'b1);

      // reset while a result is buffered
      check("pre_rst_valid", res_valid, 1'b1);
      r0_valid = 1'b1; r1_valid = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_res", res, 32'h0);
      check("mid_rst_r0_ready", r0_ready, 1'b0);
      check("mid_rst_r1_ready", r1_ready, 1'b0);
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      drive_cycle(1'b1, 32'h0000_00F0, 32'h0000_000F, 5'b00010,
                  1'b1, 32'h0, 32'h0000_0001, 5'b10000, 1'b1);
      check("post_rst_id", res_id, 1'b0);

      // randomized traffic; an unaccepted request is held unchanged
      p0 = 1'b0; p1 = 1'b0;
      for (int i = 0; i < 250; i++) begin
         if (p0) begin
            nv0 = 1'b1; na0 = r0_a; nb0 = r0_b; nt0 = r0_type;
         end else begin
            nv0 = ($urandom_range(0, 9) < 7);
            na0 = $urandom; nb0 = $urandom; nt0 = rand_type();
         end
         if (p1) begin
            nv1 = 1'b1; na1 = r1_a; nb1 = r1_b; nt1 = r1_type;
         end else begin
            nv1 = ($urandom_range(0, 9) < 7);
            na1 = $urandom; nb1 = $urandom; nt1 = rand_type();
         end
         nrdy = ($urandom_range(0, 3) != 0);
         drive_cycle(nv0, na0, nb0, nt0, nv1, na1, nb1, nt1, nrdy);
         p0 = nv0 && !last_g0;
         p1 = nv1 && !last_g1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
